// File: rtl/layer_2_conv_sequencer.sv
// Streams one IMG_SIZE x IMG_SIZE feature map from the layer buffer into a Conv2D3x3 group,
// tags each pixel with row/col, counts results and pulses done. Optional LAYER_SEQ_PERF_EN adds stall_cnt.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing buffer reads, one per src_ready cycle
// DRAIN | all reads issued, waiting for remaining results
// DONE  | one-cycle completion pulse
module layer_2_conv_sequencer #(
  parameter int IMG_SIZE   = 208,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  src_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  conv_valid_in,
  output logic [CNT_WIDTH-1:0]  pix_row,
  output logic [CNT_WIDTH-1:0]  pix_col,
  input  logic                  conv_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unexp
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] TOTAL = CNT_WIDTH'(IMG_SIZE * IMG_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST  = CNT_WIDTH'(IMG_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  logic [CNT_WIDTH-1:0]  pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic                  cvi_q;
  logic                  err_q, err_d;
  logic                  start_acc;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rd_idx_d  = rd_idx_q;
    row_d     = row_q;
    col_d     = col_q;
    res_cnt_d = res_cnt_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    rd_addr   = '0;
    start_acc = (state_q == IDLE) && start;

    if (conv_valid_out && (state_q == FETCH || state_q == DRAIN) && res_cnt_q != TOTAL)
      res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
    if (conv_valid_out && (state_q == IDLE || state_q == DONE || res_cnt_q == TOTAL))
      err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          rd_idx_d  = '0;
          row_d     = '0;
          col_d     = '0;
          res_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (src_ready) begin
            rd_en    = 1'b1;
            rd_addr  = base_q + ADDR_WIDTH'(rd_idx_q);
            rd_idx_d = rd_idx_q + CNT_WIDTH'(1);
            if (col_q == LAST) begin
              col_d = '0;
              if (row_q != LAST) row_d = row_q + CNT_WIDTH'(1);
            end else begin
              col_d = col_q + CNT_WIDTH'(1);
            end
          end
          // Both counts finishing together skips DRAIN entirely.
          if (rd_idx_d == TOTAL) state_d = (res_cnt_d == TOTAL) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (res_cnt_d == TOTAL) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pix_row_d = rd_en ? row_q : pix_row_q;
    pix_col_d = rd_en ? col_q : pix_col_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rd_idx_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      res_cnt_q <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
      cvi_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rd_idx_q  <= rd_idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      res_cnt_q <= res_cnt_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
      cvi_q     <= rd_en;
      err_q     <= err_d;
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) stall_d = '0;
    else if (state_q == FETCH && !src_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign conv_valid_in = cvi_q;
  assign pix_row       = pix_row_q;
  assign pix_col       = pix_col_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE) && !abort;
  assign err_unexp     = err_q;

endmodule

// File: tb/tb_layer_2_conv_sequencer.sv
// Directed bench for layer_2_conv_sequencer at IMG_SIZE=4; results are looped back 3 cycles
// after conv_valid_in. Expected values are hand-derived from pass length and base address.
module tb_layer_2_conv_sequencer;
  localparam int IMG = 4;
  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int NPIX = IMG * IMG;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, src_ready = 1'b0, conv_valid_out = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          rd_en, conv_valid_in, busy, done, err_unexp;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] pix_row, pix_col;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  layer_2_conv_sequencer #(.IMG_SIZE(IMG), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort), .base_addr(base_addr),
    .src_ready(src_ready), .rd_en(rd_en), .rd_addr(rd_addr), .conv_valid_in(conv_valid_in),
    .pix_row(pix_row), .pix_col(pix_col), .conv_valid_out(conv_valid_out),
    .busy(busy), .done(done), .err_unexp(err_unexp)
`ifdef LAYER_SEQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_rd = 0, n_vin = 0, n_cvo = 0, n_done = 0;
  int done_cyc = 0, last_cvo_cyc = 0, rd_first = 0, rd_last = 0;
  int sr_mode = 0, sr_phase = 0;
  logic          prev_rd_en = 1'b0, extra_en = 1'b0, extra_done = 1'b0, inj_cvo = 1'b0;
  logic [3:0]    pipe = '0;
  logic [AW-1:0] exp_base = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs on the falling edge, then observe and score outputs.
  task automatic tick(input logic st, input logic ab);
    @(negedge Clk);
    cyc++;
    start     = st;
    abort     = ab;
    src_ready = (sr_mode == 0) ? 1'b1 : (((cyc - sr_phase) % 2) == 0);
    pipe      = {pipe[2:0], conv_valid_in};
    conv_valid_out = pipe[3];
    if (pipe[3]) begin
      n_cvo++;
      last_cvo_cyc = cyc;
    end else if (extra_en && !extra_done && n_cvo == NPIX) begin
      conv_valid_out = 1'b1;
      extra_done = 1'b1;
    end else if (inj_cvo) begin
      conv_valid_out = 1'b1;
      inj_cvo = 1'b0;
    end
    #1;
    check("cvi_vs_rd_en_d1", conv_valid_in, prev_rd_en);
    if (rd_en) begin
      check("rd_addr", rd_addr, AW'(exp_base + AW'(n_rd)));
      if (n_rd == 0) rd_first = cyc;
      rd_last = cyc;
      n_rd++;
    end
    if (conv_valid_in) begin
      check("pix_row", pix_row, n_vin / IMG);
      check("pix_col", pix_col, n_vin % IMG);
      n_vin++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_rd_en = rd_en;
  endtask

  task automatic new_pass(input logic [AW-1:0] base);
    exp_base = base; base_addr = base;
    n_rd = 0; n_vin = 0; n_cvo = 0;
    extra_en = 1'b0; extra_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      tick(1'b0, 1'b0);
      k++;
    end
    check("done_within_budget", n_done - d0, 1);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (n_rd < n && k < budget) begin
      tick(1'b0, 1'b0);
      k++;
    end
    check("reads_within_budget", n_rd, n);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #3 Rst = 1'b0;
    #2;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_cvi", conv_valid_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_unexp, 0);
    check("rst_pix", {pix_row, pix_col}, 0);
    @(negedge Clk) Rst = 1'b1;
    tick(1'b0, 1'b0);

    // 1: constant src_ready from 0x0100
    sr_mode = 0;
    new_pass(16'h0100);
    tick(1'b1, 1'b0);
    check("t1_busy_at_start", busy, 0);
    tick(1'b0, 1'b0);
    check("t1_busy_after_start", busy, 1);
    wait_done(80);
    check("t1_reads", n_rd, NPIX);
    check("t1_consecutive", rd_last - rd_first, NPIX - 1);
    check("t1_valid_ins", n_vin, NPIX);
    check("t1_done_after_last_result", done_cyc, last_cvo_cyc + 1);
    check("t1_done_count", n_done, 1);
    tick(1'b0, 1'b0);
    check("t1_busy_after_done", busy, 0);
    check("t1_done_one_cycle", done, 0);
    check("t1_err_clean", err_unexp, 0);

    // 4a: result strobe while IDLE
    d0 = n_done;
    inj_cvo = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("t4_err_idle", err_unexp, 1);
    repeat (3) tick(1'b0, 1'b0);
    check("t4_err_held", err_unexp, 1);
    check("t4_done_unchanged", n_done, d0);

    // 2: src_ready toggling 1,0,1,0 starting with the first FETCH cycle
    sr_mode = 1;
    new_pass(16'h0200);
    sr_phase = cyc + 2;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("t2_err_cleared_by_start", err_unexp, 0);
    wait_done(120);
    check("t2_reads", n_rd, NPIX);
    check("t2_read_spacing", rd_last - rd_first, 2 * (NPIX - 1));
    check("t2_valid_ins", n_vin, NPIX);
`ifdef LAYER_SEQ_PERF_EN
    check("t2_stall_cnt", stall_cnt, NPIX - 1);
`endif
    tick(1'b0, 1'b0);

    // 5: start during FETCH is ignored
    sr_mode = 0;
    d0 = n_done;
    new_pass(16'h0300);
    tick(1'b1, 1'b0);
    wait_rd(5, 20);
    tick(1'b1, 1'b0);
    wait_done(80);
    check("t5_reads", n_rd, NPIX);
    check("t5_uninterrupted", rd_last - rd_first, NPIX - 1);
    check("t5_done_once", n_done - d0, 1);
    tick(1'b0, 1'b0);

    // 4b: 17th result arrives during DONE
    d0 = n_done;
    new_pass(16'h0400);
    extra_en = 1'b1;
    tick(1'b1, 1'b0);
    wait_done(80);
    tick(1'b0, 1'b0);
    check("t4_extra_sent", extra_done, 1);
    check("t4_err_17th", err_unexp, 1);
    repeat (2) tick(1'b0, 1'b0);
    check("t4_done_single", n_done - d0, 1);

    // 3: abort after 7 reads, then restart from base 0
    d0 = n_done;
    new_pass(16'h0500);
    tick(1'b1, 1'b0);
    wait_rd(7, 20);
    tick(1'b0, 1'b1);
    check("t3_rd_en_abort", rd_en, 0);
    pipe = '0;
    tick(1'b0, 1'b0);
    check("t3_idle_after_abort", busy, 0);
    check("t3_cvi_low", conv_valid_in, 0);
    repeat (4) tick(1'b0, 1'b0);
    check("t3_reads_stopped", n_rd, 7);
    check("t3_no_done", n_done, d0);
    new_pass(16'h0000);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("t3_restart_rd_en", rd_en, 1);
    check("t3_restart_addr", rd_addr, 0);
    wait_done(80);
    check("t3_restart_reads", n_rd, NPIX);
    tick(1'b0, 1'b0);

    // 6: asynchronous reset mid-FETCH
    new_pass(16'h0600);
    tick(1'b1, 1'b0);
    wait_rd(6, 20);
    #2 Rst = 1'b0;
    #1;
    check("t6_rd_en", rd_en, 0);
    check("t6_rd_addr", rd_addr, 0);
    check("t6_cvi", conv_valid_in, 0);
    check("t6_pix", {pix_row, pix_col}, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err_unexp, 0);
    @(negedge Clk) Rst = 1'b1;
    pipe = '0;
    prev_rd_en = 1'b0;
    tick(1'b0, 1'b0);
    check("t6_idle_after_release", busy, 0);
    check("t6_no_read_after_release", rd_en, 0);

    // Address wraps modulo 2^ADDR_WIDTH
    new_pass(16'hFFF8);
    tick(1'b1, 1'b0);
    wait_done(80);
    check("wrap_reads", n_rd, NPIX);
    tick(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_2_conv_sequencer.md
Name: layer_2_conv_sequencer

Overview:
- Sequences one feature-map pass through the layer-2 Conv2D3x3 array.
- On start, it streams IMG_SIZE x IMG_SIZE pixel words from the feature-map buffer and drives the array's shared valid_in.
- It tags each pixel with row/col for border padding masks, counts returned results, and pulses done when the pass completes.
- One instance sits between the layer buffer and each featuremap group.

Parameters:
IMG_SIZE, 208, image width = height in pixels
ADDR_WIDTH, 16, buffer read address width; must be >= clog2(IMG_SIZE*IMG_SIZE)
CNT_WIDTH, 16, pixel/result counter width; must be >= clog2(IMG_SIZE*IMG_SIZE+1)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a pass (honoured only in IDLE)
abort  in  1  synchronous cancel of the current pass
base_addr  in  ADDR_WIDTH  buffer address of pixel (0,0), latched on accepted start
src_ready  in  1  buffer can accept a read this cycle
rd_en  out  1  buffer read strobe
rd_addr  out  ADDR_WIDTH  buffer read address
conv_valid_in  out  1  valid to Conv2D3x3 array, aligned with buffer read data
pix_row  out  CNT_WIDTH  row of the pixel qualified by conv_valid_in
pix_col  out  CNT_WIDTH  column of the pixel qualified by conv_valid_in
conv_valid_out  in  1  result strobe from Conv2D3x3 array
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at pass completion
err_unexp  out  1  sticky: conv_valid_out seen in IDLE or after all results counted

Behaviour:
- Reset (Rst=0, async) sets all outputs and counters to 0, state to IDLE, and err_unexp to 0.
- States:
  - IDLE: start=1 latches base_addr, clears counters and goes to FETCH.
  - FETCH: each cycle with src_ready=1, drives rd_en=1 and rd_addr = base_addr + rd_idx, then increments rd_idx. When rd_idx reaches IMG_SIZE*IMG_SIZE, goes to DRAIN.
  - DRAIN: waits while res_cnt < IMG_SIZE*IMG_SIZE, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- rd_en and rd_addr are combinational from state, src_ready and rd_idx.
- With src_ready=0 in FETCH: rd_en=0, rd_idx holds, no bubble tracking needed.
- Buffer read latency is 1 cycle:
  - conv_valid_in is rd_en registered once.
  - pix_row/pix_col are the row/col of the issued read, registered with it.
- Row/col counters: col increments per read; at col=IMG_SIZE-1 it wraps to 0 and row increments. Row never exceeds IMG_SIZE-1.
- res_cnt increments on conv_valid_out in FETCH or DRAIN, saturating at IMG_SIZE*IMG_SIZE.
- FETCH goes straight to DONE (skipping DRAIN) if both counts are complete in the same cycle.
- err_unexp sets in two cases:
  - conv_valid_out=1 while in IDLE or DONE.
  - conv_valid_out=1 while res_cnt is already at IMG_SIZE*IMG_SIZE.
  - err_unexp clears only on reset or an accepted start.
- start while busy is ignored; no effect on counters.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; rd_en=0 in that same cycle.
  - conv_valid_in=0 from the next cycle.
  - No done pulse.
  - abort takes priority over start and over completion.
- Simultaneous abort and start in IDLE: start is accepted.
- busy is high from the cycle after an accepted start through the DONE cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).

Optional Feature:
LAYER_SEQ_PERF_EN
- Defined: adds output stall_cnt [31:0], which counts FETCH cycles with src_ready=0. It clears on accepted start, holds after done, and saturates at all-ones.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan (IMG_SIZE=4):
1. base_addr=0x0100, start, src_ready=1 constant, conv_valid_out returned 3 cycles after each conv_valid_in -> rd_addr 0x0100..0x010F on 16 consecutive cycles; pix_row/col walk (0,0)..(3,3); one done pulse after the 16th conv_valid_out; busy low the cycle after.
2. src_ready toggling 1,0,1,0 -> exactly 16 rd_en pulses with no address skipped or repeated; conv_valid_in pattern equals rd_en delayed by 1.
3. abort asserted after 7 reads -> rd_en low that cycle; state IDLE; no done; a new start with base_addr=0 restarts at rd_addr=0 and pix (0,0).
4. 17th conv_valid_out pulse, and a conv_valid_out pulse in IDLE -> err_unexp=1, held until next start; done count unchanged.
5. start pulsed during FETCH -> ignored; rd_idx sequence uninterrupted.
6. Rst asserted low mid-FETCH, asynchronously -> all outputs 0 immediately, before the next clock edge; after release, state IDLE.
